muldiv_unit: RTL and testbench

//  Iterative 32-bit multiply/divide engine behind the ALU's HI/LO path.
//  - Accepts one mult/div request from the execute stage.
//  - Runs a radix-2 shift-add multiply or restoring divide for 32 iterations.
//  - Returns a 64-bit result as hi/lo with a one-cycle done pulse.
//  - done is what the control unit uses as InstDone to release the PC/HI/LO write.

---
 rtl/muldiv_unit_if.sv | 25 ++
 rtl/muldiv_unit.sv | 194 +++++++++++++++++++
 tb/tb_muldiv_unit.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the execute stage and the iterative mult/div engine.
// The execute stage drives the master side and the engine implements the slave side.
interface muldiv_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             div_by_zero;

  modport master (
    output start, op, a, b,
    input  busy, done, hi, lo, div_by_zero
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, hi, lo, div_by_zero
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply / restoring divide feeding HI/LO; done pulse releases the writeback.
// Optional macro MULDIV_SIGNED_EN adds signed ops (op[0]) with a one-cycle sign FIX state.
module muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic          clk,
  input  logic          rst_n,
  muldiv_unit_if.slave  bus
);

`ifdef MULDIV_SIGNED_EN
  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;
`endif

  state_t             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [2*WIDTH:0]   acc_q;
  logic [WIDTH-1:0]   b_q;
  logic               is_div_q;
  logic               dbz_pend_q;
  logic               busy_q;
  logic               done_q;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;
  logic               dbz_q;

  logic [WIDTH-1:0]   opa_d;
  logic [WIDTH-1:0]   opb_d;
  logic [WIDTH:0]     mul_sum_d;
  logic [2*WIDTH:0]   mul_acc_d;
  logic [WIDTH:0]     rem_sh_d;
  logic [WIDTH-1:0]   rem_diff_d;
  logic [2*WIDTH:0]   div_acc_d;

`ifdef MULDIV_SIGNED_EN
  logic               sgn_op_q;
  logic               neg_lo_q;
  logic               neg_hi_q;
  logic [2*WIDTH:0]   fix_acc_d;

  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v);
    return ~v + {{(WIDTH-1){1'b0}}, 1'b1};
  endfunction

  function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] v);
    return ~v + {{(2*WIDTH-1){1'b0}}, 1'b1};
  endfunction

  function automatic logic [WIDTH-1:0] abs_w(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? neg_w(v) : v;
  endfunction
`else
  logic               unused_op0_s;
  assign unused_op0_s = bus.op[0];
`endif

  // Operand conditioning at accept: magnitudes for signed ops, raw values otherwise.
  always_comb begin
    opa_d = bus.a;
    opb_d = bus.b;
`ifdef MULDIV_SIGNED_EN
    if (bus.op[0]) begin
      opa_d = abs_w(bus.a);
      opb_d = abs_w(bus.b);
    end else begin
      opa_d = bus.a;
      opb_d = bus.b;
    end
`endif
  end

  // One shift-add multiply step: acc holds {carry, upper, multiplier/low product}.
  always_comb begin
    mul_sum_d = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, b_q};
    if (acc_q[0]) begin
      mul_acc_d = {1'b0, mul_sum_d, acc_q[WIDTH-1:1]};
    end else begin
      mul_acc_d = {1'b0, acc_q[2*WIDTH:1]};
    end
  end

  // One restoring-divide step: acc holds {0, remainder, quotient}.
  always_comb begin
    rem_sh_d   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    rem_diff_d = rem_sh_d[WIDTH-1:0] - b_q;
    if (rem_sh_d >= {1'b0, b_q}) begin
      div_acc_d = {1'b0, rem_diff_d, acc_q[WIDTH-2:0], 1'b1};
    end else begin
      div_acc_d = {1'b0, rem_sh_d[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
    end
  end

`ifdef MULDIV_SIGNED_EN
  // Sign restoration applied in FIX; remainder follows the dividend's sign.
  always_comb begin
    fix_acc_d = acc_q;
    if (is_div_q) begin
      fix_acc_d = {1'b0,
                   neg_hi_q ? neg_w(acc_q[2*WIDTH-1:WIDTH]) : acc_q[2*WIDTH-1:WIDTH],
                   neg_lo_q ? neg_w(acc_q[WIDTH-1:0])       : acc_q[WIDTH-1:0]};
    end else begin
      fix_acc_d = {1'b0, neg_lo_q ? neg_2w(acc_q[2*WIDTH-1:0]) : acc_q[2*WIDTH-1:0]};
    end
  end
`endif

  // Control FSM with registered busy/done/hi/lo/div_by_zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      acc_q      <= '0;
      b_q        <= '0;
      is_div_q   <= 1'b0;
      dbz_pend_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      dbz_q      <= 1'b0;
`ifdef MULDIV_SIGNED_EN
      sgn_op_q   <= 1'b0;
      neg_lo_q   <= 1'b0;
      neg_hi_q   <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            busy_q   <= 1'b1;
            cnt_q    <= '0;
            is_div_q <= bus.op[1];
            b_q      <= opb_d;
`ifdef MULDIV_SIGNED_EN
            sgn_op_q <= bus.op[0];
            neg_lo_q <= bus.op[0] & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
            neg_hi_q <= bus.op[0] & bus.a[WIDTH-1];
`endif
            // Divide by zero skips the iterations and reports {a, all-ones}.
            if (bus.op[1] && (bus.b == {WIDTH{1'b0}})) begin
              acc_q      <= {1'b0, bus.a, {WIDTH{1'b1}}};
              dbz_pend_q <= 1'b1;
              state_q    <= S_DONE;
            end else begin
              acc_q      <= {1'b0, {WIDTH{1'b0}}, opa_d};
              dbz_pend_q <= 1'b0;
              state_q    <= S_CALC;
            end
          end
        end
        S_CALC: begin
          acc_q <= is_div_q ? div_acc_d : mul_acc_d;
          cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
          if (cnt_q == CNT_W'(WIDTH-1)) begin
`ifdef MULDIV_SIGNED_EN
            state_q <= sgn_op_q ? S_FIX : S_DONE;
`else
            state_q <= S_DONE;
`endif
          end
        end
`ifdef MULDIV_SIGNED_EN
        S_FIX: begin
          acc_q   <= fix_acc_d;
          state_q <= S_DONE;
        end
`endif
        S_DONE: begin
          hi_q    <= acc_q[2*WIDTH-1:WIDTH];
          lo_q    <= acc_q[WIDTH-1:0];
          dbz_q   <= dbz_pend_q;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.hi          = hi_q;
  assign bus.lo          = lo_q;
  assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed-vector bench for muldiv_unit: results, latency, busy span, div-by-zero,
// start-while-busy, return-to-IDLE accept and async reset abort.
module tb_muldiv_unit;
  localparam int WIDTH = 32;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  muldiv_unit_if #(.WIDTH(WIDTH)) bus ();

  muldiv_unit #(.WIDTH(WIDTH), .CNT_W(6)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Issue one op, then scramble operands; lat counts samples from the accept edge to done.
  task automatic run_op(input string tag, input logic [1:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                        input logic exp_dbz, input int exp_lat);
    int lat;
    int busy_n;
    lat    = 0;
    busy_n = 0;
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.a     = $urandom;
    bus.b     = $urandom;
    for (int k = 1; k <= 100; k++) begin
      if (bus.done) begin
        lat = k;
        break;
      end
      if (bus.busy) busy_n++;
      @(posedge clk); #1;
    end
    chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    chk({tag, "_busy"}, 64'(busy_n), 64'(exp_lat - 1));
    chk({tag, "_busy_at_done"}, {63'd0, bus.busy}, 64'd0);
    chk({tag, "_hilo"}, {bus.hi, bus.lo}, {exp_hi, exp_lo});
    chk({tag, "_dbz"}, {63'd0, bus.div_by_zero}, {63'd0, exp_dbz});
  endtask

  initial begin
    int dones;
    int first_k;
    int second_k;

    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.op    = 2'b00;
    bus.a     = 32'd0;
    bus.b     = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_outs", {bus.hi, bus.lo}, 64'd0);
    chk("rst_flags", {61'd0, bus.busy, bus.done, bus.div_by_zero}, 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op("multu_max", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 34);
    run_op("multu_shift", 2'b00, 32'h1234_5678, 32'h0000_0010, 32'h0000_0001, 32'h2345_6780, 1'b0, 34);
    run_op("divu_100_7", 2'b10, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 34);
    run_op("divu_dbz", 2'b10, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 1'b1, 2);

    repeat (3) @(posedge clk);
    #1;
    chk("hold_hilo", {bus.hi, bus.lo}, {32'd5, 32'hFFFF_FFFF});
    chk("hold_dbz", {63'd0, bus.div_by_zero}, 64'd1);

    run_op("divu_by_one", 2'b10, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'hFFFF_FFFF, 1'b0, 34);
    run_op("divu_small", 2'b10, 32'd7, 32'd100, 32'd7, 32'd0, 1'b0, 34);

`ifdef MULDIV_SIGNED_EN
    run_op("mult_neg", 2'b01, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 35);
    run_op("div_neg", 2'b11, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 35);
    run_op("mult_minmin", 2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0, 35);
    run_op("div_min_m1", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0, 35);
`else
    run_op("op01_unsigned", 2'b01, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, 32'hFFFF_FFFE, 1'b0, 34);
    run_op("op11_unsigned", 2'b11, 32'hFFFF_FFF9, 32'd2, 32'h0000_0001, 32'h7FFF_FFFC, 1'b0, 34);
`endif

    // start held high across an op, then a new request in the return-to-IDLE cycle.
    dones     = 0;
    first_k   = 0;
    second_k  = 0;
    bus.start = 1'b1;
    bus.op    = 2'b10;
    bus.a     = 32'd100;
    bus.b     = 32'd7;
    for (int k = 1; k <= 120; k++) begin
      @(posedge clk); #1;
      if (first_k != 0 && k == first_k + 1) begin
        chk("b2b_accept_busy", {63'd0, bus.busy}, 64'd1);
        bus.start = 1'b0;
        bus.a     = 32'd0;
        bus.b     = 32'd0;
      end
      if (bus.done) begin
        dones++;
        if (dones == 1) begin
          first_k = k;
          chk("b2b_first", {bus.hi, bus.lo}, {32'd2, 32'd14});
          bus.op = 2'b00;
          bus.a  = 32'd123456;
          bus.b  = 32'd789;
        end else begin
          second_k = k;
          chk("b2b_second", {bus.hi, bus.lo}, 64'd97406784);
          break;
        end
      end
    end
    bus.start = 1'b0;
    chk("b2b_first_lat", 64'(first_k), 64'd34);
    chk("b2b_second_lat", 64'(second_k), 64'd68);
    chk("b2b_dones", 64'(dones), 64'd2);

    // Async reset at iteration 10 aborts the op.
    bus.start = 1'b1;
    bus.op    = 2'b00;
    bus.a     = 32'hDEAD_BEEF;
    bus.b     = 32'h0000_1234;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort_hilo", {bus.hi, bus.lo}, 64'd0);
    chk("abort_flags", {61'd0, bus.busy, bus.done, bus.div_by_zero}, 64'd0);
    dones = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (bus.done) dones++;
    end
    rst_n = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (bus.done) dones++;
    end
    chk("abort_no_done", 64'(dones), 64'd0);
    run_op("after_reset", 2'b10, 32'd1000, 32'd10, 32'd0, 32'd100, 1'b0, 34);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
